// File: rtl/button_event_arbiter.sv
// Push-button front end: sync, debounce and press detection, then a round-robin
// arbiter into a small event FIFO. Define AUTO_REPEAT_EN to add hold auto-repeat.
module button_event_arbiter #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_CYCLES   = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         pb,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic [NUM_BTN-1:0]         pending,
  output logic                       overflow
);

  localparam int unsigned IDW = $clog2(NUM_BTN);
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  if (NUM_BTN < 2 || NUM_BTN > 8 || DEBOUNCE_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("button_event_arbiter: unsupported parameter set");
  end

  logic [NUM_BTN-1:0] s1, s2, stable, stable_d;
  logic [DCW-1:0]     dcnt [NUM_BTN];
  logic [NUM_BTN-1:0] press_c, take_c;
  logic               gnt_c, pop_c, full_c;
  logic [IDW-1:0]     gnt_id_c, head_c, ptr;
  logic [IDW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]      rd, wr, rd_c;
  logic [CW-1:0]      count, count_c;

  // Two-flop synchronizer and per-button debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) dcnt[i] <= '0;
    end else begin
      s1       <= pb;
      s2       <= s1;
      stable_d <= stable;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (s2[i] == stable[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= s2[i];
          dcnt[i]   <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RCW = $clog2(REPEAT_CYCLES);

  logic [RCW-1:0]     rcnt [NUM_BTN];
  logic [NUM_BTN-1:0] rep;

  // rep is high one cycle out of every REPEAT_CYCLES of continuous hold
  always_ff @(posedge clk) begin
    if (reset) begin
      rep <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (!stable[i]) begin
          rcnt[i] <= '0;
          rep[i]  <= 1'b0;
        end else if (rcnt[i] == RCW'(REPEAT_CYCLES - 1)) begin
          rcnt[i] <= '0;
          rep[i]  <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + RCW'(1);
          rep[i]  <= 1'b0;
        end
      end
    end
  end

  assign press_c = (stable & ~stable_d) | (rep & stable);
`else
  assign press_c = stable & ~stable_d;
`endif

  assign pop_c  = (count != '0) && evt_ready;
  assign full_c = (count == CW'(FIFO_DEPTH));

  // Round-robin search starting one past the last granted button
  always_comb begin
    int unsigned idx;
    idx      = 0;
    gnt_c    = 1'b0;
    gnt_id_c = '0;
    take_c   = '0;
    if (!full_c) begin
      for (int unsigned k = 1; k <= NUM_BTN; k++) begin
        idx = (32'(ptr) + k) % NUM_BTN;
        if (!gnt_c && pending[IDW'(idx)]) begin
          gnt_c    = 1'b1;
          gnt_id_c = IDW'(idx);
        end
      end
    end
    if (gnt_c) take_c[gnt_id_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      ptr      <= IDW'(NUM_BTN - 1);
    end else begin
      pending  <= (pending & ~take_c) | press_c;
      overflow <= overflow | (|(press_c & pending & ~take_c));
      if (gnt_c) ptr <= gnt_id_c;
    end
  end

  // Next head: a push into an (after-pop) empty queue bypasses the memory
  always_comb begin
    count_c = count + CW'(gnt_c) - CW'(pop_c);
    rd_c    = pop_c ? rd + AW'(1) : rd;
    head_c  = ((count - CW'(pop_c)) == '0) ? gnt_id_c : mem[rd_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (gnt_c) begin
        mem[wr] <= gnt_id_c;
        wr      <= wr + AW'(1);
      end
      rd        <= rd_c;
      count     <= count_c;
      evt_valid <= (count_c != '0);
      evt_id    <= head_c;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized and directed bench for button_event_arbiter with a queue-based
// reference model and a scoreboard monitor on the event handshake.
module tb_button_event_arbiter;

  localparam int NB    = 4;
  localparam int DEB   = 16;
  localparam int DEPTH = 4;
  localparam int REP   = 64;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  bit         clk = 1'b0;
  logic       reset;
  logic [3:0] pb;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] pending;
  logic       overflow;

  button_event_arbiter #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .pb(pb), .evt_valid(evt_valid), .evt_id(evt_id),
    .evt_ready(evt_ready), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: history-window debounce, queue FIFO, modular RR search
  logic [3:0] m_s1, m_s2, m_stable, m_stable_d, m_pend, m_press, m_take, m_ns;
  bit         m_ovf;
  int         m_ptr;
  int         m_g;
  int         m_fifo[$];
  int         exp_q[$];
  bit         hist[NB][$];
  int         age[NB];
  bit         all_diff;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0; m_pend = '0;
      m_ovf = 1'b0; m_ptr = NB - 1;
      m_fifo.delete(); exp_q.delete();
      for (int i = 0; i < NB; i++) begin hist[i].delete(); age[i] = 0; end
    end else begin
      m_press = m_stable & ~m_stable_d;
      if (REP_EN)
        for (int i = 0; i < NB; i++)
          if (m_stable[i] && age[i] > 0 && age[i] % REP == 0) m_press[i] = 1'b1;
      m_g = -1;
      if (m_fifo.size() < DEPTH)
        for (int k = 1; k <= NB; k++)
          if (m_g < 0 && m_pend[(m_ptr + k) % NB]) m_g = (m_ptr + k) % NB;
      m_take = '0;
      if (m_g >= 0) m_take[m_g] = 1'b1;
      m_ovf  = m_ovf | (|(m_press & m_pend & ~m_take));
      m_pend = (m_pend & ~m_take) | m_press;
      if (m_fifo.size() > 0 && evt_ready) void'(m_fifo.pop_front());
      if (m_g >= 0) begin
        m_fifo.push_back(m_g);
        exp_q.push_back(m_g);
        m_ptr = m_g;
      end
      m_ns = m_stable;
      for (int i = 0; i < NB; i++) begin
        hist[i].push_back(m_s2[i]);
        if (hist[i].size() > DEB) void'(hist[i].pop_front());
        all_diff = (hist[i].size() == DEB);
        foreach (hist[i][j]) if (hist[i][j] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) m_ns[i] = ~m_stable[i];
      end
      for (int i = 0; i < NB; i++)
        age[i] = (m_ns[i] && m_stable[i]) ? age[i] + 1 : 0;
      m_stable_d = m_stable;
      m_stable   = m_ns;
      m_s2       = m_s1;
      m_s1       = pb;
    end
  end

  // Monitor: state compare every cycle, id compare on each accepted event
  always @(negedge clk) begin
    if (armed) begin
      check("evt_valid", int'(evt_valid), int'(m_fifo.size() > 0));
      check("pending", int'(pending), int'(m_pend));
      check("overflow", int'(overflow), int'(m_ovf));
      if (evt_valid && evt_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("evt_unexpected", int'(evt_id), -1);
        else check("evt_id", int'(evt_id), exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Edges from the first one sampling the new input until evt_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (evt_valid) break;
    end
  endtask

  task automatic press(input logic [3:0] p, input int hold, input int gap);
    pb = p; cyc(hold); pb = '0; cyc(gap);
  endtask

  int lat;
  int hs0;

  initial begin
    pb = '0; evt_ready = 1'b0; reset = 1'b1;
    cyc(3);
    reset = 1'b0; armed = 1'b1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);

    // Single press with latency measurement; valid after D+3 edges past the sampling edge
    hs0 = hs_cnt;
    pb = 4'b0100;
    wait_valid(lat);
    check("lat_single", lat, DEB + 4);
    check("id_single", int'(evt_id), 2);
    cyc(40 - lat);
    pb = '0;
    evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    cyc(40);
    check("single_drained", int'(evt_valid), 0);
    check("single_one_evt", hs_cnt - hs0, 1);

    // Glitch shorter than the debounce window
    press(4'b0001, 10, 30);
    check("glitch_pending", int'(pending), 0);
    check("glitch_valid", int'(evt_valid), 0);

    // Round-robin burst, twice
    evt_ready = 1'b1;
    hs0 = hs_cnt;
    press(4'b1111, 30, 30);
    press(4'b1111, 30, 30);
    check("rr_count", hs_cnt - hs0, 8);

    // Backpressure and overflow
    evt_ready = 1'b0;
    press(4'b1111, 25, 25);
    press(4'b0001, 25, 25);
    check("bp_pending", int'(pending), 1);
    check("bp_no_ovf", int'(overflow), 0);
    press(4'b0001, 25, 25);
    check("bp_ovf", int'(overflow), 1);
    hs0 = hs_cnt;
    evt_ready = 1'b1; cyc(12); evt_ready = 1'b0;
    check("bp_drain", hs_cnt - hs0, 5);

    // Reset mid-operation with a button held through it
    press(4'b0001, 25, 25);
    press(4'b0010, 25, 25);
    press(4'b0100, 25, 25);
    check("mid_valid", int'(evt_valid), 1);
    pb = 4'b0010; cyc(5);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_pending", int'(pending), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    hs0 = hs_cnt;
    wait_valid(lat);
    check("lat_reset", lat, DEB + 4);
    check("id_reset", int'(evt_id), 1);
    evt_ready = 1'b1; cyc(40); pb = '0; cyc(30);
    check("reset_one_evt", hs_cnt - hs0, 1);

    if (REP_EN) begin
      hs0 = hs_cnt;
      press(4'b1000, 300, 40);
      check("repeat_count", hs_cnt - hs0, 5);
    end

    // Randomized segments with occasional reset
    for (int s = 0; s < 140; s++) begin
      pb = 4'($urandom_range(0, 15));
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; cyc(1); reset = 1'b0;
      end
      cyc($urandom_range(1, 40));
    end

    pb = '0; evt_ready = 1'b1;
    cyc(80);
    check("sb_drained", exp_q.size(), 0);
    check("end_valid", int'(evt_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Front end for all player push-buttons. Each raw button is synchronized and debounced, and every press becomes a single-cycle press event.
- Presses from several buttons are shared round-robin into one 4-deep event queue.
- The queue drains to the game-logic FSM over a valid/ready handshake.
- Replaces per-button ad hoc edge detectors wired directly into game logic.

Parameters:
- NUM_BTN, 4: number of buttons (2..8).
- DEBOUNCE_CYCLES, 16: cycles a synchronized level must hold before it is accepted (≥2).
- FIFO_DEPTH, 4: event queue depth (power of 2).
- REPEAT_CYCLES, 1024: auto-repeat period. Used only with AUTO_REPEAT_EN.

Ports:
- clk, in, 1: single system clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- pb, in, NUM_BTN: raw asynchronous push-buttons, active high.
- evt_valid, out, 1: queue head holds an event.
- evt_id, out, clog2(NUM_BTN): button index of the head event.
- evt_ready, in, 1: consumer accepts the head event this cycle.
- pending, out, NUM_BTN: per-button latched, not-yet-queued press.
- overflow, out, 1: sticky; a press was dropped.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. While reset is high at a clk edge, every register clears. Reset values: evt_valid=0, evt_id=0, pending=0, overflow=0, FIFO empty, debounced state=0, RR pointer=NUM_BTN-1.
- Synchronizer: per bit, two flops, pb→s1→s2.
- Debounce, per button:
  - Counter clears whenever s2==stable.
  - Counter increments while s2!=stable.
  - When the counter==DEBOUNCE_CYCLES-1 and s2!=stable: stable<=s2 and counter<=0.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
- Press pulse: rise = stable & ~stable_d, one cycle wide per press. Releases produce nothing.
- Pending bit:
  - Set on the edge after rise.
  - Cleared on the edge the button is granted.
  - If a rise and a grant hit the same button in the same cycle, the new press is kept (pending stays 1).
  - If a rise arrives while pending is 1 and no grant occurs, the press is dropped and overflow<=1.
- Arbiter:
  - Combinational round-robin over pending.
  - Search starts at pointer+1 mod NUM_BTN.
  - At most one grant per cycle, and only when the FIFO is not full (registered count).
  - On a grant: push the index and pointer<=granted index.
  - FIFO full: no grant, and pending bits hold.
- FIFO:
  - evt_valid = ~empty; evt_id = head.
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - Pointers wrap mod FIFO_DEPTH.
  - evt_id holds stable while evt_valid=1 and evt_ready=0.
- Latency: with FIFO empty and no other pending, evt_valid rises DEBOUNCE_CYCLES+3 edges after the first edge that samples pb=1.
- Reset mid-operation: queued and pending events are discarded. A button held through reset is debounced from stable=0 and yields exactly one event, DEBOUNCE_CYCLES+3 edges after reset deasserts.

Optional Feature:
- AUTO_REPEAT_EN defined:
  - Per-button repeat counter runs while stable=1 and clears on stable=0.
  - Every REPEAT_CYCLES cycles of continuous hold, it generates an additional press pulse, handled exactly like rise (including overflow rules).
  - First repeat comes REPEAT_CYCLES cycles after the initial rise.
- AUTO_REPEAT_EN not defined: no repeat logic is synthesized, REPEAT_CYCLES is ignored, and a hold yields exactly one event.

Test Plan:
- Single press: pb[2] held 40 cycles with DEBOUNCE_CYCLES=16. evt_valid=1 and evt_id=2 after exactly 19 edges. One pop with evt_ready=1 → evt_valid=0, and no second event.
- Glitch: pb[0] high for 10 cycles, then low → no event, pending=0.
- Round-robin: all 4 buttons rise in the same cycle, evt_ready=1 → ids 0,1,2,3 on consecutive cycles. Repeat the burst → again 0,1,2,3.
- Backpressure/overflow: evt_ready=0; press buttons 0-3, then button 0 again twice. FIFO holds 4 events and pending[0]=1. The second extra press sets overflow=1. Draining yields 0,1,2,3,0.
- Reset mid-operation: 3 queued events with reset asserted 1 cycle → evt_valid=0, pending=0, overflow=0 next cycle. Held pb[1] yields one event 19 edges after reset deasserts.
- AUTO_REPEAT_EN with REPEAT_CYCLES=64: hold pb[3] 300 cycles → events for button 3 at the initial press, then +64, +128, +192, +256 cycles.
